tcb_lib_arbiter_multiplexer: RTL and testbench

- N-to-1 TCB interconnect: IFN manager-side request ports feed one subordinate-side port.
- This is the counterpart of the decoder/demultiplexer pair, which goes 1-to-N.
- Round-robin arbitration selects one request per cycle. A DLY-deep ownership pipeline routes each response back to its originating port.
- Sits between CPU/DMA managers and a shared memory or peripheral bus.

---
 rtl/tcb_lib_arbiter_multiplexer.sv | 130 +++++++++++++
 tb/tb_tcb_lib_arbiter_multiplexer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_lib_arbiter_multiplexer.sv
// N-to-1 TCB multiplexer: round-robin grant with stall lock, and a DLY-deep ownership
// pipeline that steers each response strobe and error back to the port that issued it.
module tcb_lib_arbiter_multiplexer #(
  parameter int unsigned DLY = 1,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned BEN = DAT / 8,
  parameter int unsigned IFN = 3,
  parameter int unsigned IFL = $clog2(IFN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IFN-1:0]     sub_vld,
  input  logic [IFN-1:0]     sub_wen,
  input  logic [IFN*ADR-1:0] sub_adr,
  input  logic [IFN*BEN-1:0] sub_ben,
  input  logic [IFN*DAT-1:0] sub_wdt,
  output logic [IFN-1:0]     sub_rdy,
  output logic [DAT-1:0]     sub_rdt,
  output logic [IFN-1:0]     sub_err,
  output logic [IFN-1:0]     sub_rsp,
  output logic               man_vld,
  output logic               man_wen,
  output logic [ADR-1:0]     man_adr,
  output logic [BEN-1:0]     man_ben,
  output logic [DAT-1:0]     man_wdt,
  input  logic               man_rdy,
  input  logic [DAT-1:0]     man_rdt,
  input  logic               man_err,
  output logic [IFL-1:0]     sel
);

  logic [IFL-1:0] ptr_q;
  logic           lck_q;
  logic [IFL-1:0] lsel_q;
  logic [IFL-1:0] grant;
  logic [IFL-1:0] ptr_nxt;
  logic           hs;

  // First requester at or after ptr; a stalled grant stays pinned while its port still requests.
  always_comb begin
    logic        found;
    int unsigned j;
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < IFN; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= IFN) j = j - IFN;
      if (!found && sub_vld[IFL'(j)]) begin
        found = 1'b1;
        grant = IFL'(j);
      end
    end
    if (lck_q && sub_vld[lsel_q]) grant = lsel_q;
    if (!rst) grant = '0;
  end

  assign sel     = grant;
  assign man_vld = rst & (|sub_vld);
  assign hs      = man_vld & man_rdy;
  assign ptr_nxt = (sel == IFL'(IFN - 1)) ? '0 : sel + IFL'(1);

  always_comb begin
    man_wen = sub_wen[0];
    man_adr = sub_adr[ADR-1:0];
    man_ben = sub_ben[BEN-1:0];
    man_wdt = sub_wdt[DAT-1:0];
    for (int unsigned i = 1; i < IFN; i++) begin
      if (sel == IFL'(i)) begin
        man_wen = sub_wen[i];
        man_adr = sub_adr[i*ADR +: ADR];
        man_ben = sub_ben[i*BEN +: BEN];
        man_wdt = sub_wdt[i*DAT +: DAT];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < IFN; i++) begin
      sub_rdy[i] = rst & man_rdy & sub_vld[i] & (sel == IFL'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      lck_q  <= 1'b0;
      lsel_q <= '0;
    end else begin
      lck_q  <= man_vld & ~man_rdy;
      lsel_q <= sel;
      if (hs) ptr_q <= ptr_nxt;
    end
  end

  if (DLY > 0) begin : g_pipe
    logic [DLY-1:0]     own_vld_q;
    logic [DLY*IFL-1:0] own_idx_q;
    logic [IFL-1:0]     own_last;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        own_vld_q <= '0;
        own_idx_q <= '0;
      end else begin
        own_vld_q <= (own_vld_q << 1) | DLY'(hs);
        own_idx_q <= (own_idx_q << IFL) | (DLY*IFL)'(sel);
      end
    end

    assign own_last = own_idx_q[DLY*IFL-1 -: IFL];

    always_comb begin
      for (int unsigned i = 0; i < IFN; i++) begin
        sub_rsp[i] = own_vld_q[DLY-1] & (own_last == IFL'(i));
      end
    end
  end else begin : g_comb
    always_comb begin
      for (int unsigned i = 0; i < IFN; i++) begin
        sub_rsp[i] = hs & (sel == IFL'(i));
      end
    end
  end

  assign sub_err = {IFN{man_err}} & sub_rsp;
  assign sub_rdt = man_rdt;

endmodule

// File: tb/tb_tcb_lib_arbiter_multiplexer.sv
// Bench for tcb_lib_arbiter_multiplexer: directed scenarios plus randomized traffic checked
// against a queue-based model of grants and response ownership (DLY=1 and DLY=2 instances).
module tb_tcb_lib_arbiter_multiplexer;
  localparam int unsigned ADR = 32;
  localparam int unsigned DAT = 32;
  localparam int unsigned BEN = 4;
  localparam int unsigned IFN = 3;
  localparam int unsigned IFL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IFN-1:0]          vld, wen;
  logic [IFN-1:0][ADR-1:0] adr;
  logic [IFN-1:0][BEN-1:0] ben;
  logic [IFN-1:0][DAT-1:0] wdt;
  logic                    man_rdy, man_err;
  logic [DAT-1:0]          man_rdt;

  logic [IFN-1:0] d1_rdy, d1_err, d1_rsp, d2_rdy, d2_err, d2_rsp;
  logic [DAT-1:0] d1_rdt, d1_wdt, d2_rdt, d2_wdt;
  logic [ADR-1:0] d1_adr, d2_adr;
  logic [BEN-1:0] d1_ben, d2_ben;
  logic           d1_vld, d1_wen, d2_vld, d2_wen;
  logic [IFL-1:0] d1_sel, d2_sel;

  tcb_lib_arbiter_multiplexer #(.DLY(1), .ADR(ADR), .DAT(DAT), .BEN(BEN), .IFN(IFN)) u_dut (
    .clk(clk), .rst(rst), .sub_vld(vld), .sub_wen(wen), .sub_adr(adr), .sub_ben(ben),
    .sub_wdt(wdt), .sub_rdy(d1_rdy), .sub_rdt(d1_rdt), .sub_err(d1_err), .sub_rsp(d1_rsp),
    .man_vld(d1_vld), .man_wen(d1_wen), .man_adr(d1_adr), .man_ben(d1_ben), .man_wdt(d1_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err), .sel(d1_sel)
  );

  tcb_lib_arbiter_multiplexer #(.DLY(2), .ADR(ADR), .DAT(DAT), .BEN(BEN), .IFN(IFN)) u_dut2 (
    .clk(clk), .rst(rst), .sub_vld(vld), .sub_wen(wen), .sub_adr(adr), .sub_ben(ben),
    .sub_wdt(wdt), .sub_rdy(d2_rdy), .sub_rdt(d2_rdt), .sub_err(d2_err), .sub_rsp(d2_rsp),
    .man_vld(d2_vld), .man_wen(d2_wen), .man_adr(d2_adr), .man_ben(d2_ben), .man_wdt(d2_wdt),
    .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err), .sel(d2_sel)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: rotating priority pointer, stall owner, and a list of (due cycle, owner).
  typedef struct {int t; int own;} rsp_t;
  rsp_t           q1[$], q2[$];
  logic [IFL-1:0] m_ptr, m_lsel;
  bit             m_lck;
  int             cyc = 0;

  function automatic logic [IFL-1:0] exp_sel();
    if (!rst) return '0;
    if (m_lck && vld[m_lsel]) return m_lsel;
    for (int k = 0; k < int'(IFN); k++) begin
      int j = (int'(m_ptr) + k) % int'(IFN);
      if (vld[IFL'(j)]) return IFL'(j);
    end
    return '0;
  endfunction

  function automatic logic [IFN-1:0] exp_rsp(input bit deep);
    logic [IFN-1:0] r = '0;
    if (!rst) return '0;
    if (deep) begin
      foreach (q2[k]) if (q2[k].t == cyc) r |= IFN'(1) << q2[k].own;
    end else begin
      foreach (q1[k]) if (q1[k].t == cyc) r |= IFN'(1) << q1[k].own;
    end
    return r;
  endfunction

  task automatic model_step();
    logic [IFL-1:0] s;
    bit             req;
    if (!rst) begin
      m_ptr = '0; m_lck = 1'b0; m_lsel = '0;
      q1.delete(); q2.delete();
    end else begin
      s   = exp_sel();
      req = (vld != '0);
      if (req && man_rdy) begin
        q1.push_back('{t: cyc + 1, own: int'(s)});
        q2.push_back('{t: cyc + 2, own: int'(s)});
        m_ptr = IFL'((int'(s) + 1) % int'(IFN));
      end
      m_lck  = req && !man_rdy;
      m_lsel = s;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    vld = '1; man_rdy = 1'b1; man_err = 1'b1;
    @(negedge clk);
    checks++; if (d1_sel !== '0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", d1_sel); end
    checks++; if (d1_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", d1_vld); end
    checks++; if (d1_rdy !== '0 || d2_rdy !== '0) begin errors++; $display("FAIL reset_rdy: got %b/%b exp 000", d1_rdy, d2_rdy); end
    checks++; if (d1_rsp !== '0 || d2_rsp !== '0) begin errors++; $display("FAIL reset_rsp: got %b/%b exp 000", d1_rsp, d2_rsp); end
    checks++; if (d1_err !== '0 || d2_err !== '0) begin errors++; $display("FAIL reset_err: got %b/%b exp 000", d1_err, d2_err); end
    tick();
    rst = 1'b1; vld = '0; man_err = 1'b0;
    @(negedge clk); tick();
  endtask

  task automatic test_round_robin();
    vld = 3'b111; wen = '0; man_rdy = 1'b1;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd0 || d1_rdy !== 3'b001) begin errors++; $display("FAIL rr_grant0: got sel %0d rdy %b exp 0 001", d1_sel, d1_rdy); end
    tick();
    vld = 3'b110; man_rdt = 32'h03020100;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd1 || d1_rdy !== 3'b010) begin errors++; $display("FAIL rr_grant1: got sel %0d rdy %b exp 1 010", d1_sel, d1_rdy); end
    checks++; if (d1_rsp !== 3'b001 || d1_rdt !== 32'h03020100) begin errors++; $display("FAIL rr_rsp0: got %b %h exp 001 03020100", d1_rsp, d1_rdt); end
    tick();
    vld = 3'b100; man_rdt = 32'h13121110;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd2 || d1_rdy !== 3'b100) begin errors++; $display("FAIL rr_grant2: got sel %0d rdy %b exp 2 100", d1_sel, d1_rdy); end
    checks++; if (d1_rsp !== 3'b010 || d1_rdt !== 32'h13121110) begin errors++; $display("FAIL rr_rsp1: got %b %h exp 010 13121110", d1_rsp, d1_rdt); end
    tick();
    vld = '0; man_rdt = 32'h23222120;
    @(negedge clk);
    checks++; if (d1_rsp !== 3'b100 || d1_rdt !== 32'h23222120) begin errors++; $display("FAIL rr_rsp2: got %b %h exp 100 23222120", d1_rsp, d1_rdt); end
    tick();
    @(negedge clk); tick();
  endtask

  task automatic test_single();
    vld = 3'b010; wen = 3'b010; man_rdy = 1'b1;
    @(negedge clk);
    checks++; if (d1_adr !== 32'h04 || d1_wdt !== 32'h13121110 || d1_wen !== 1'b1) begin errors++; $display("FAIL single_payload: got %h %h %b exp 00000004 13121110 1", d1_adr, d1_wdt, d1_wen); end
    checks++; if (d1_sel !== 2'd1 || d1_rdy !== 3'b010) begin errors++; $display("FAIL single_grant: got sel %0d rdy %b exp 1 010", d1_sel, d1_rdy); end
    tick();
    vld = '0; wen = '0;
    @(negedge clk);
    checks++; if (d1_rsp !== 3'b010) begin errors++; $display("FAIL single_rsp: got %b exp 010", d1_rsp); end
    tick();
    vld = 3'b111; man_rdy = 1'b0;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd2) begin errors++; $display("FAIL single_ptr: got %0d exp 2", d1_sel); end
    tick();
    vld = '0; man_rdy = 1'b1;
    @(negedge clk); tick();
  endtask

  task automatic test_wrap();
    vld = 3'b100;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd2 || d1_rdy !== 3'b100) begin errors++; $display("FAIL wrap_grant2: got sel %0d rdy %b exp 2 100", d1_sel, d1_rdy); end
    tick();
    vld = 3'b011;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d exp 0", d1_sel); end
    tick();
    vld = 3'b010;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd1) begin errors++; $display("FAIL wrap_next: got %0d exp 1", d1_sel); end
    tick();
    @(negedge clk);
    checks++; if (d1_sel !== 2'd1 || d1_rdy !== 3'b010) begin errors++; $display("FAIL wrap_skip: got sel %0d rdy %b exp 1 010", d1_sel, d1_rdy); end
    tick();
    vld = '0;
    @(negedge clk); tick();
  endtask

  task automatic test_stall();
    vld = 3'b100; man_rdy = 1'b1;
    @(negedge clk); tick();
    man_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) vld = 3'b101;
      @(negedge clk);
      checks++; if (d1_sel !== 2'd2 || d1_rdy !== '0 || d1_vld !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got sel %0d rdy %b vld %b exp 2 000 1", c, d1_sel, d1_rdy, d1_vld); end
      tick();
    end
    man_rdy = 1'b1;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd2 || d1_rdy !== 3'b100) begin errors++; $display("FAIL stall_release: got sel %0d rdy %b exp 2 100", d1_sel, d1_rdy); end
    tick();
    vld = 3'b001;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd0 || d1_rdy !== 3'b001) begin errors++; $display("FAIL stall_next: got sel %0d rdy %b exp 0 001", d1_sel, d1_rdy); end
    tick();
    vld = '0;
    @(negedge clk); tick();
  endtask

  task automatic test_error();
    vld = 3'b001; wen = '0; man_rdy = 1'b1;
    @(negedge clk); tick();
    vld = '0; man_err = 1'b1;
    @(negedge clk);
    checks++; if (d1_err !== 3'b001 || d1_rsp !== 3'b001) begin errors++; $display("FAIL err_owner: got err %b rsp %b exp 001 001", d1_err, d1_rsp); end
    tick();
    @(negedge clk);
    checks++; if (d1_err !== '0) begin errors++; $display("FAIL err_spurious: got %b exp 000", d1_err); end
    tick();
    man_err = 1'b0;
    @(negedge clk); tick();
  endtask

  task automatic test_random();
    logic [IFL-1:0] es;
    logic [IFN-1:0] erdy, er1, er2;
    logic           ev;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < int'(IFN); i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1; wen[i] = 1'($urandom); adr[i] = $urandom;
          ben[i] = 4'($urandom); wdt[i] = $urandom;
        end
      end
      man_rdy = ($urandom_range(0, 3) != 0);
      man_err = 1'($urandom);
      man_rdt = $urandom;
      @(negedge clk);
      es   = exp_sel();
      ev   = (vld != '0);
      erdy = (ev && man_rdy) ? (IFN'(1) << es) : '0;
      er1  = exp_rsp(1'b0);
      er2  = exp_rsp(1'b1);
      checks++; if (d1_sel !== es || d2_sel !== es) begin errors++; $display("FAIL rnd_sel n=%0d: got %0d/%0d exp %0d", n, d1_sel, d2_sel, es); end
      checks++; if (d1_vld !== ev || d2_vld !== ev) begin errors++; $display("FAIL rnd_vld n=%0d: got %b/%b exp %b", n, d1_vld, d2_vld, ev); end
      checks++; if ({d1_wen, d1_adr, d1_ben, d1_wdt} !== {wen[es], adr[es], ben[es], wdt[es]}) begin errors++; $display("FAIL rnd_payload n=%0d: got %b %h %h %h exp %b %h %h %h", n, d1_wen, d1_adr, d1_ben, d1_wdt, wen[es], adr[es], ben[es], wdt[es]); end
      checks++; if ({d2_wen, d2_adr, d2_ben, d2_wdt} !== {wen[es], adr[es], ben[es], wdt[es]}) begin errors++; $display("FAIL rnd_payload2 n=%0d: got %h %h exp %h %h", n, d2_adr, d2_wdt, adr[es], wdt[es]); end
      checks++; if (d1_rdy !== erdy || d2_rdy !== erdy) begin errors++; $display("FAIL rnd_rdy n=%0d: got %b/%b exp %b", n, d1_rdy, d2_rdy, erdy); end
      checks++; if (d1_rsp !== er1) begin errors++; $display("FAIL rnd_rsp1 n=%0d: got %b exp %b", n, d1_rsp, er1); end
      checks++; if (d2_rsp !== er2) begin errors++; $display("FAIL rnd_rsp2 n=%0d: got %b exp %b", n, d2_rsp, er2); end
      checks++; if (d1_err !== (man_err ? er1 : '0) || d2_err !== (man_err ? er2 : '0)) begin errors++; $display("FAIL rnd_err n=%0d: got %b/%b exp %b/%b", n, d1_err, d2_err, man_err ? er1 : '0, man_err ? er2 : '0); end
      checks++; if (d1_rdt !== man_rdt || d2_rdt !== man_rdt) begin errors++; $display("FAIL rnd_rdt n=%0d: got %h/%h exp %h", n, d1_rdt, d2_rdt, man_rdt); end
      tick();
      if (ev && man_rdy) vld[es] = 1'b0;
    end
    vld = '0; man_rdy = 1'b1; man_err = 1'b0;
    @(negedge clk); tick();
    @(negedge clk); tick();
  endtask

  task automatic test_reset_mid();
    vld = 3'b010; man_rdy = 1'b1;
    @(negedge clk);
    checks++; if (d2_sel !== 2'd1 || d2_rdy !== 3'b010) begin errors++; $display("FAIL rmid_grant: got sel %0d rdy %b exp 1 010", d2_sel, d2_rdy); end
    tick();
    rst = 1'b0; vld = 3'b111; man_err = 1'b1;
    @(negedge clk);
    checks++; if (d1_sel !== '0 || d2_sel !== '0 || d1_vld !== 1'b0 || d2_vld !== 1'b0) begin errors++; $display("FAIL rmid_out: got sel %0d/%0d vld %b/%b exp 0 0", d1_sel, d2_sel, d1_vld, d2_vld); end
    checks++; if ({d1_rdy, d2_rdy, d1_rsp, d2_rsp, d1_err, d2_err} !== '0) begin errors++; $display("FAIL rmid_zero: got %b %b %b %b %b %b exp all 0", d1_rdy, d2_rdy, d1_rsp, d2_rsp, d1_err, d2_err); end
    tick();
    rst = 1'b1; vld = '0;
    @(negedge clk);
    checks++; if (d2_rsp !== '0 || d2_err !== '0 || d1_rsp !== '0) begin errors++; $display("FAIL rmid_norsp: got %b %b %b exp 000", d2_rsp, d2_err, d1_rsp); end
    tick();
    vld = 3'b110; man_err = 1'b0;
    @(negedge clk);
    checks++; if (d1_sel !== 2'd1 || d2_sel !== 2'd1) begin errors++; $display("FAIL rmid_first: got %0d/%0d exp 1", d1_sel, d2_sel); end
    tick();
    vld = '0;
    @(negedge clk); tick();
  endtask

  initial begin
    rst = 1'b0; vld = '0; wen = '0; man_rdy = 1'b0; man_err = 1'b0; man_rdt = '0;
    m_ptr = '0; m_lsel = '0; m_lck = 1'b0;
    for (int i = 0; i < int'(IFN); i++) begin
      adr[i] = ADR'(4 * i);
      ben[i] = '1;
      wdt[i] = {8'(16 * i + 3), 8'(16 * i + 2), 8'(16 * i + 1), 8'(16 * i)};
    end
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_stall();
    test_error();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
